// File: rtl/instr_mem_decoder_main_pkg.sv
// instr_mem_decoder_main_pkg
// Shared definitions for the instruction-memory / decoder front end:
//   - default word width and memory depth
//   - FSM state encodings (fetch, decode, read)
//   - bit positions of the instruction fields
// No ports; imported by instr_mem_decoder_main and mem16x16.
package instr_mem_decoder_main_pkg;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_READ   = 2'd2
    } state_t;

    // Instruction layout: [15:12] opcode, [11:8] destination (unused here),
    // [7:4] first source select, [3:0] second source select.
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int SEL1_MSB   = 7;
    localparam int SEL1_LSB   = 4;
    localparam int SEL2_MSB   = 3;
    localparam int SEL2_LSB   = 0;

endpackage

// File: rtl/instr_mem_decoder_main_mem16x16.sv
// mem16x16
// Small word-addressed memory used both as the instruction ROM and as the
// data RAM / register file. The storage array is called 'mem' so it can be
// preloaded hierarchically (direct writes from a bench).
// Reads are combinational from the supplied (registered) addresses, so there
// is no read-latency cycle. N_RD independent read ports are provided so the
// register file can serve two operands at once.
// Ports:
//   clock    in   write clock
//   en       in   chip enable; gates both reads and writes
//   rw       in   1 = read, 0 = write
//   rd_addr  in   N_RD read addresses
//   rd_data  out  N_RD read words (zero when not enabled for reading)
//   wr_addr  in   write address
//   wr_data  in   write data
module mem16x16 #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int N_RD   = 1,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                         clock,
    input  logic                         en,
    input  logic                         rw,
    input  logic [N_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [N_RD-1:0][DATA_W-1:0]  rd_data,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data
);
    import instr_mem_decoder_main_pkg::*;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Contents are deliberately not reset so preloaded images survive reset.
    always_ff @(posedge clock) begin
        if (en && !rw) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        assign rd_data[p] = (en && rw) ? mem[rd_addr[p]] : '0;
    end

endmodule

// File: rtl/instr_mem_decoder_main.sv
// instr_mem_decoder_main
// Front end of the datapath. A program counter walks a 16-word instruction
// ROM; each instruction is decoded into an opcode and two register selects,
// and the two selected data-RAM words are presented to the ALU. One
// instruction completes every three clocks (FETCH, DECODE, READ).
// Ports:
//   clock    in   single clock, rising edge
//   reset    in   synchronous, active-high
//   source1  out  RAM word addressed by select1
//   source2  out  RAM word addressed by select2
//   opcode   out  opcode field of the current instruction
// The opcode of instruction N+1 changes one clock before its sources, so the
// three outputs form a consistent set only on the edge after READ.
module instr_mem_decoder_main #(
    parameter int DATA_W = instr_mem_decoder_main_pkg::DATA_W,
    parameter int DEPTH  = instr_mem_decoder_main_pkg::DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    output logic [DATA_W-1:0] source1,
    output logic [DATA_W-1:0] source2,
    output logic [3:0]        opcode
);
    import instr_mem_decoder_main_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);

    state_t              current_state;
    state_t              next_state;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   inst;
    logic [ADDR_W-1:0]   select1;
    logic [ADDR_W-1:0]   select2;
    logic                rw_RAM;
    logic                chip_enable;
    logic                rw;

    logic                load_inst;
    logic                load_dec;
    logic                load_src;

    logic [0:0][ADDR_W-1:0] rom_addr;
    logic [0:0][DATA_W-1:0] rom_data;
    logic [1:0][ADDR_W-1:0] ram_addr;
    logic [1:0][DATA_W-1:0] ram_data;

    assign rom_addr[0] = pc;
    assign ram_addr[0] = select1;
    assign ram_addr[1] = select2;

    // The ROM is never written; its write port is tied off.
    mem16x16 #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .N_RD   (1)
    ) rom (
        .clock   (clock),
        .en      (chip_enable),
        .rw      (rw),
        .rd_addr (rom_addr),
        .rd_data (rom_data),
        .wr_addr ('0),
        .wr_data ('0)
    );

    // The RAM is only read here: rw_RAM is held high and the write data is
    // tied to zero, so the write port can never fire.
    mem16x16 #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .N_RD   (2)
    ) ram (
        .clock   (clock),
        .en      (1'b1),
        .rw      (rw_RAM),
        .rd_addr (ram_addr),
        .rd_data (ram_data),
        .wr_addr ('0),
        .wr_data ('0)
    );

    // Next-state and per-state load strobes. The unused encoding falls back
    // to FETCH without touching any datapath register. A fetch with the ROM
    // disabled still advances the FSM but keeps the previous instruction.
    always_comb begin
        next_state = S_FETCH;
        load_inst  = 1'b0;
        load_dec   = 1'b0;
        load_src   = 1'b0;
        case (current_state)
            S_FETCH: begin
                next_state = S_DECODE;
                load_inst  = chip_enable && rw;
            end
            S_DECODE: begin
                next_state = S_READ;
                load_dec   = 1'b1;
            end
            S_READ: begin
                next_state = S_FETCH;
                load_src   = 1'b1;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // State, PC, decode and output registers. Reset takes priority over any
    // FSM step; control bits only ever take their reset values and then hold.
    // The PC is 4 bits and wraps silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            current_state <= S_FETCH;
            pc            <= '0;
            inst          <= '0;
            select1       <= '0;
            select2       <= '0;
            opcode        <= '0;
            source1       <= '0;
            source2       <= '0;
            rw_RAM        <= 1'b1;
            chip_enable   <= 1'b1;
            rw            <= 1'b1;
        end else begin
            current_state <= next_state;
            if (load_inst) begin
                inst <= rom_data[0];
            end
            if (load_dec) begin
                opcode  <= inst[OPCODE_MSB:OPCODE_LSB];
                select1 <= inst[SEL1_MSB:SEL1_LSB];
                select2 <= inst[SEL2_MSB:SEL2_LSB];
            end
            if (load_src) begin
                source1 <= ram_data[0];
                source2 <= ram_data[1];
                pc      <= pc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_decoder_main.sv
// tb_instr_mem_decoder_main
// Bench for instr_mem_decoder_main. A behavioural model predicts opcode,
// sources and PC from the number of clock edges since reset and the memory
// images the bench loaded; directed literal checks pin that model and cover
// reset, illegal-state recovery and the ROM chip-enable behaviour.
module tb_instr_mem_decoder_main;
    import instr_mem_decoder_main_pkg::*;

    logic        clock;
    logic        reset;
    logic [15:0] source1;
    logic [15:0] source2;
    logic [3:0]  opcode;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] rom_m [16];
    logic [15:0] ram_m [16];
    int          cyc;
    bit          model_on = 1'b0;

    instr_mem_decoder_main dut (
        .clock   (clock),
        .reset   (reset),
        .source1 (source1),
        .source2 (source2),
        .opcode  (opcode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edges since the last reset edge.
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Memory images are mirrored in the model arrays as they are loaded.
    task loadRom(input logic [3:0] a, input logic [15:0] v);
        dut.rom.mem[a] <= v;
        rom_m[a] = v;
    endtask

    task loadRam(input logic [3:0] a, input logic [15:0] v);
        dut.ram.mem[a] <= v;
        ram_m[a] = v;
    endtask

    task applyStimulus(input logic rst_val, input int cycles);
        reset = rst_val;
        repeat (cycles) @(negedge clock);
    endtask

    task doReset();
        applyStimulus(1'b1, 1);
        model_on = 1'b1;
        reset    = 1'b0;
    endtask

    // Model: every instruction takes three edges. After n edges, (n+1)/3
    // decodes and n/3 reads have completed, and the PC counts reads mod 16.
    function automatic logic [31:0] expOpcode(input int n);
        int d;
        logic [15:0] w;
        d = (n + 1) / 3;
        if (d == 0) return 32'd0;
        w = rom_m[(d - 1) % 16];
        return 32'(w[15:12]);
    endfunction

    function automatic logic [31:0] expSource(input int n, input bit second);
        int r;
        logic [15:0] w;
        r = n / 3;
        if (r == 0) return 32'd0;
        w = rom_m[(r - 1) % 16];
        return second ? 32'(ram_m[w[3:0]]) : 32'(ram_m[w[7:4]]);
    endfunction

    always @(posedge clock) begin
        #1;
        if (model_on) begin
            checkOutput("model_opcode",  32'(opcode),  expOpcode(cyc));
            checkOutput("model_source1", 32'(source1), expSource(cyc, 1'b0));
            checkOutput("model_source2", 32'(source2), expSource(cyc, 1'b1));
            checkOutput("model_pc",      32'(dut.pc),  32'((cyc / 3) % 16));
        end
    end

    initial begin
        reset = 1'b1;

        // Basic fetch/decode/read of the first instruction.
        for (int i = 0; i < 16; i++) begin
            loadRom(4'(i), 16'h0000);
            loadRam(4'(i), 16'h0000);
        end
        loadRom(4'd0, 16'h1234);
        loadRam(4'd3, 16'hAAAA);
        loadRam(4'd4, 16'h5555);
        doReset();
        checkOutput("rst_state",   32'(dut.current_state), 32'd0);
        checkOutput("rst_pc",      32'(dut.pc),            32'd0);
        checkOutput("rst_inst",    32'(dut.inst),          32'd0);
        checkOutput("rst_sel1",    32'(dut.select1),       32'd0);
        checkOutput("rst_sel2",    32'(dut.select2),       32'd0);
        checkOutput("rst_opcode",  32'(opcode),            32'd0);
        checkOutput("rst_src1",    32'(source1),           32'd0);
        checkOutput("rst_src2",    32'(source2),           32'd0);
        checkOutput("rst_rw_ram",  32'(dut.rw_RAM),        32'd1);
        checkOutput("rst_ce",      32'(dut.chip_enable),   32'd1);
        checkOutput("rst_rw",      32'(dut.rw),            32'd1);
        applyStimulus(1'b0, 2);
        checkOutput("t1_opcode",   32'(opcode),            32'h1);
        applyStimulus(1'b0, 1);
        checkOutput("t1_src1",     32'(source1),           32'hAAAA);
        checkOutput("t1_src2",     32'(source2),           32'h5555);
        checkOutput("t1_pc",       32'(dut.pc),            32'd1);

        // PC wrap across all 16 words, equal selects.
        model_on = 1'b0;
        for (int i = 0; i < 16; i++) loadRom(4'(i), 16'hF0FF);
        loadRam(4'd15, 16'hBEEF);
        doReset();
        applyStimulus(1'b0, 48);
        checkOutput("wrap_pc",     32'(dut.pc),            32'd0);
        checkOutput("wrap_opcode", 32'(opcode),            32'hF);
        checkOutput("wrap_src1",   32'(source1),           32'hBEEF);
        checkOutput("wrap_src2",   32'(source2),           32'hBEEF);

        // Two-instruction sequence with swapped selects.
        model_on = 1'b0;
        for (int i = 0; i < 16; i++) loadRom(4'(i), 16'h0000);
        loadRom(4'd0, 16'h2012);
        loadRom(4'd1, 16'h3021);
        loadRam(4'd1, 16'h0001);
        loadRam(4'd2, 16'h0002);
        doReset();
        applyStimulus(1'b0, 3);
        checkOutput("seq_op0",     32'(opcode),            32'h2);
        checkOutput("seq_a_src1",  32'(source1),           32'h0001);
        checkOutput("seq_a_src2",  32'(source2),           32'h0002);
        applyStimulus(1'b0, 2);
        checkOutput("seq_op1",     32'(opcode),            32'h3);
        checkOutput("seq_hold_s1", 32'(source1),           32'h0001);
        applyStimulus(1'b0, 1);
        checkOutput("seq_b_src1",  32'(source1),           32'h0002);
        checkOutput("seq_b_src2",  32'(source2),           32'h0001);

        // Reset asserted while in DECODE.
        applyStimulus(1'b0, 1);
        checkOutput("mid_in_dec",  32'(dut.current_state), 32'd1);
        applyStimulus(1'b1, 1);
        checkOutput("mid_state",   32'(dut.current_state), 32'd0);
        checkOutput("mid_pc",      32'(dut.pc),            32'd0);
        checkOutput("mid_opcode",  32'(opcode),            32'd0);
        checkOutput("mid_src1",    32'(source1),           32'd0);
        checkOutput("mid_src2",    32'(source2),           32'd0);
        applyStimulus(1'b0, 1);
        checkOutput("mid_refetch", 32'(dut.inst),          32'h2012);
        applyStimulus(1'b0, 2);
        checkOutput("mid_pc1",     32'(dut.pc),            32'd1);

        // Illegal state encoding recovers to FETCH with no side effects.
        model_on = 1'b0;
        dut.current_state <= state_t'(2'd3);
        applyStimulus(1'b0, 1);
        checkOutput("ill_state",   32'(dut.current_state), 32'd0);
        checkOutput("ill_pc",      32'(dut.pc),            32'd1);
        checkOutput("ill_opcode",  32'(opcode),            32'h2);
        checkOutput("ill_src1",    32'(source1),           32'h0001);
        checkOutput("ill_src2",    32'(source2),           32'h0002);
        checkOutput("ill_inst",    32'(dut.inst),          32'h2012);
        applyStimulus(1'b0, 1);
        checkOutput("ill_fetch",   32'(dut.inst),          32'h3021);

        // ROM disabled before FETCH: the previous instruction repeats.
        doReset();
        applyStimulus(1'b0, 3);
        model_on = 1'b0;
        dut.chip_enable <= 1'b0;
        applyStimulus(1'b0, 2);
        checkOutput("ce_inst",     32'(dut.inst),          32'h2012);
        checkOutput("ce_opcode",   32'(opcode),            32'h2);
        applyStimulus(1'b0, 1);
        checkOutput("ce_src1",     32'(source1),           32'h0001);
        checkOutput("ce_src2",     32'(source2),           32'h0002);
        checkOutput("ce_pc",       32'(dut.pc),            32'd2);
        dut.chip_enable <= 1'b1;
        applyStimulus(1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
